// File: rtl/register_writeback.sv
// register_writeback
//   Architectural register file (32 x DATA_W) and write-back commit stage of the
//   MIPS datapath, with a per-register pending-write scoreboard for decode stalls.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   issue_valid  decode issues an instruction writing issue_rd
//   issue_rd     destination register of the issuing instruction
//   issue_ready  issue may be accepted this cycle
//   wb_valid     write-back result present this cycle
//   wb_rd        write-back destination register
//   wb_data      write-back value
//   out_register full register array to the read stage (r0 reads as 0)
//   pending      bit i set while register i has outstanding writes
//   wb_error     sticky: a write-back hit a register with no outstanding write
module register_writeback #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNT_W     = 2,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] out_register [32],
    output logic [31:0]       pending,
    output logic              wb_error
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [DATA_W-1:0] regs_q  [32];
    logic [CNT_W-1:0]  count_q [32];
    logic [CNT_W-1:0]  count_d [32];
    logic              wb_error_q;
    logic              wb_error_d;
    logic              issue_acc;
    logic              wb_hit;

    // Ready looks only at the current count; a same-cycle write-back does not
    // free a slot until the next cycle.
    assign issue_ready = (issue_rd == 5'd0) || (count_q[issue_rd] != CntMax);
    assign issue_acc   = issue_valid && issue_ready;
    assign wb_hit      = wb_valid && (wb_rd != 5'd0);

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            count_d[i] = count_q[i];
            if (i != 0) begin
                logic inc;
                logic dec;
                inc = issue_acc && (issue_rd == 5'(i));
                // Decrement gated at zero so a spurious write-back cannot wrap.
                dec = wb_hit && (wb_rd == 5'(i)) && (count_q[i] != '0);
                if (inc && !dec) begin
                    count_d[i] = count_q[i] + CntOne;
                end else if (dec && !inc) begin
                    count_d[i] = count_q[i] - CntOne;
                end
            end
        end
    end

    assign wb_error_d = wb_error_q || (wb_hit && (count_q[wb_rd] == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i]  <= '0;
                count_q[i] <= '0;
            end
            wb_error_q <= 1'b0;
        end else begin
            if (wb_hit) begin
                regs_q[wb_rd] <= wb_data;
            end
            for (int i = 0; i < 32; i++) begin
                count_q[i] <= count_d[i];
            end
            wb_error_q <= wb_error_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            out_register[i] = regs_q[i];
            if (WB_BYPASS && wb_hit && (wb_rd == 5'(i))) begin
                out_register[i] = wb_data;
            end
            pending[i] = (count_q[i] != '0);
        end
        out_register[0] = '0;
        pending[0]      = 1'b0;
    end

    assign wb_error = wb_error_q;

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback (WB_BYPASS=1, CNT_W=2).
module tb_register_writeback;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] out_register [32];
    logic [31:0] pending;
    logic        wb_error;

    int n_cmp = 0;
    int n_err = 0;

    register_writeback #(
        .DATA_W   (32),
        .CNT_W    (2),
        .WB_BYPASS(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_register(out_register),
        .pending     (pending),
        .wb_error    (wb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled
    // only between edges.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        wb_valid    = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'h0;
    endtask

    logic [31:0] acc;

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        acc = '0;
        for (int i = 0; i < 32; i++) acc |= out_register[i];
        check_eq("rst_regs", acc, 32'h0);
        check_eq("rst_pending", pending, 32'h0);
        check_eq("rst_ready", {31'b0, issue_ready}, 32'h1);
        check_eq("rst_err", {31'b0, wb_error}, 32'h0);

        // Basic write to r5
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1 check_eq("r5_ready", {31'b0, issue_ready}, 32'h1);
        tick();
        issue_valid = 1'b0;
        #1 check_eq("r5_pend_after_issue", pending, 32'h0000_0020);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1 check_eq("r5_bypass", out_register[5], 32'hDEAD_BEEF);
        check_eq("r6_no_bypass", out_register[6], 32'h0);
        tick();
        idle_inputs();
        #1 check_eq("r5_stored", out_register[5], 32'hDEAD_BEEF);
        check_eq("r5_pend_after_wb", pending, 32'h0);
        check_eq("r5_err", {31'b0, wb_error}, 32'h0);

        // r0 protection
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1 check_eq("r0_ready", {31'b0, issue_ready}, 32'h1);
        tick();
        idle_inputs();
        #1 check_eq("r0_pend_issue", pending, 32'h0);
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234_5678;
        #1 check_eq("r0_bypass", out_register[0], 32'h0);
        tick();
        idle_inputs();
        #1 check_eq("r0_stored", out_register[0], 32'h0);
        check_eq("r0_pend_wb", pending, 32'h0);
        check_eq("r0_err", {31'b0, wb_error}, 32'h0);

        // Saturation on r7: three accepted issues fill the counter
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        tick();
        tick();
        #1 check_eq("r7_stall", {31'b0, issue_ready}, 32'h0);
        check_eq("r7_pend", pending, 32'h0000_0080);
        // Fourth issue held alongside a write-back: still stalled this cycle
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_0777;
        #1 check_eq("r7_stall_wb", {31'b0, issue_ready}, 32'h0);
        tick();
        wb_valid = 1'b0;
        #1 check_eq("r7_ready_next", {31'b0, issue_ready}, 32'h1);
        tick();
        issue_valid = 1'b0;
        #1 check_eq("r7_full_again", {31'b0, issue_ready}, 32'h0);
        check_eq("r7_data", out_register[7], 32'h0000_0777);
        check_eq("r7_err", {31'b0, wb_error}, 32'h0);

        // Simultaneous issue + wb to r9 with count 1
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0099;
        tick();
        idle_inputs();
        #1 check_eq("r9_pend", pending[9], 1'b1);
        check_eq("r9_data", out_register[9], 32'h0000_0099);
        // Count must be exactly 1: one more write-back clears it without error
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0999;
        tick();
        idle_inputs();
        #1 check_eq("r9_pend_clear", pending[9], 1'b0);
        check_eq("r9_data2", out_register[9], 32'h0000_0999);
        check_eq("r9_err", {31'b0, wb_error}, 32'h0);

        // Spurious write-back to r3
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0033;
        tick();
        idle_inputs();
        #1 check_eq("r3_data", out_register[3], 32'h0000_0033);
        check_eq("r3_err", {31'b0, wb_error}, 32'h1);
        check_eq("r3_pend", pending, 32'h0000_0080);
        tick();
        check_eq("r3_err_held", {31'b0, wb_error}, 32'h1);

        // Outstanding r3, r4, then reset with a write-back in the same cycle
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        tick();
        idle_inputs();
        #1 check_eq("pre_rst_pend", pending, 32'h0000_0098);
        reset = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_00FF;
        issue_valid = 1'b1; issue_rd = 5'd10;
        tick();
        reset = 1'b0;
        idle_inputs();
        #1 check_eq("mid_rst_pend", pending, 32'h0);
        check_eq("mid_rst_err", {31'b0, wb_error}, 32'h0);
        check_eq("mid_rst_r3", out_register[3], 32'h0);
        check_eq("mid_rst_r4", out_register[4], 32'h0);
        check_eq("mid_rst_r5", out_register[5], 32'h0);
        check_eq("mid_rst_r7", out_register[7], 32'h0);
        check_eq("mid_rst_ready", {31'b0, issue_ready}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_writeback.md
Name: register_writeback

Overview:
- Sequential register-file storage and write-back stage of the MIPS datapath. It sits directly upstream of the combinational register read stage.
- Holds the 32 x 32-bit architectural registers and commits WB-stage results into them.
- Drives the full register array to the read stage.
- Keeps a per-register pending-write scoreboard, so decode can stall on destinations whose writes have not yet committed.

Parameters:
- DATA_W, 32, register width in bits.
- CNT_W, 2, width of each per-register pending-write counter (max outstanding writes per register = 2^CNT_W - 1).
- WB_BYPASS, 1, 1 = out_register shows the same-cycle write-back value combinationally; 0 = written value visible only after the clock edge.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- issue_valid  input  1  decode issues an instruction that will write issue_rd.
- issue_rd  input  5  destination register of the issuing instruction.
- issue_ready  output  1  issue may be accepted this cycle.
- wb_valid  input  1  write-back result present this cycle.
- wb_rd  input  5  write-back destination register.
- wb_data  input  DATA_W  write-back value.
- out_register  output  [DATA_W-1:0] x [31:0] (unpacked)  register array feeding the read stage.
- pending  output  32  bit i = 1 when register i has at least one outstanding write.
- wb_error  output  1  sticky flag: a write-back arrived for a register with no outstanding write.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; all state changes occur on the rising edge of clk.
- Reset (reset=1 at an edge):
  - All 32 registers clear to 0.
  - All pending counters clear to 0, so pending = 32'h0.
  - wb_error clears to 0.
  - Reset overrides any issue or write-back in the same cycle; nothing is written or counted.
  - Reset mid-operation discards all outstanding pending state.
  - After reset: issue_ready = 1, out_register all 0.
- Register 0:
  - out_register[0] = 0 always, including under bypass.
  - Write-backs to r0 are ignored: no write, no counter change, no wb_error.
  - Issues to r0 are always accepted, never counted; pending[0] = 0 always.
- Write commit: at an edge with wb_valid=1 and wb_rd!=0, register[wb_rd] <= wb_data. The new value is visible on out_register from the next cycle (latency 1).
- Bypass, WB_BYPASS=1: while wb_valid=1 and wb_rd!=0, out_register[wb_rd] = wb_data combinationally in the same cycle. All other entries show stored values.
- Bypass, WB_BYPASS=0: out_register is purely the stored array.
- Issue handshake:
  - issue_ready = 1 if issue_rd==0 or count[issue_rd] < 2^CNT_W-1. It is combinational from the current count and ignores any write-back in the same cycle (conservative stall).
  - An issue is accepted when issue_valid && issue_ready.
  - Decode must hold issue_valid/issue_rd stable until accepted.
- Counter update per register i (i != 0), at each edge:
  - inc = accepted issue with issue_rd==i.
  - dec = wb_valid with wb_rd==i and count[i] > 0.
  - inc only: count+1. dec only: count-1. Both: unchanged. Neither: unchanged.
  - A counter never wraps: issue_ready blocks overflow, and the decrement is gated at 0.
- Pending: pending[i] = (count[i] != 0), registered (follows the counters).
- Error:
  - A write-back with wb_valid=1, wb_rd!=0 and count[wb_rd]==0 still writes the register and leaves the count at 0.
  - It sets wb_error=1 at that edge. wb_error is held until reset.
  - A simultaneous accepted issue to the same register in that cycle still increments the count (count 0 -> 1), and wb_error is still set.

Test Plan:
- Reset then idle: assert reset 2 cycles -> out_register all 0, pending=0, issue_ready=1, wb_error=0.
- Basic write: issue r5; next cycle wb r5 with 32'hDEADBEEF.
  - pending[5]=1 after the issue edge.
  - WB_BYPASS=1: out_register[5]=DEADBEEF in the wb cycle. WB_BYPASS=0: it appears after the edge.
  - pending[5]=0 after the wb edge.
- r0 protection: issue r0, then wb r0 with 32'h12345678 -> out_register[0]=0, pending[0]=0, wb_error=0.
- Saturation (CNT_W=2):
  - Issue r7 three times -> issue_ready=0 while issue_rd=7.
  - A fourth issue held with simultaneous wb r7 -> still stalled that cycle, accepted the next cycle; count stays at 3.
- Simultaneous issue+wb to r9 with count 1 -> count stays 1, pending[9]=1, register updated.
- Spurious wb: wb r3 with count 0 -> register[3] written, wb_error=1 and held. Reset mid-stream (pending r3,r4 outstanding) -> pending=0, registers 0, wb_error=0.
